// File: rtl/mac_learning_table_if.sv
// Signal bundle between the header parser / forwarding stage and
// mac_learning_table. The table itself connects through the slave modport,
// while the surrounding pipeline (or a bench) uses the master modport.
interface mac_learning_table_if #(
  parameter int NUM_IQ_BITS       = 3,
  parameter int NUM_OUTPUT_QUEUES = 8
);
  logic [47:0]                  dst_mac;
  logic [47:0]                  src_mac;
  logic [15:0]                  ethertype;
  logic                         eth_done;
  logic [NUM_IQ_BITS-1:0]       src_port;
  logic [NUM_OUTPUT_QUEUES-1:0] dst_ports;
  logic [15:0]                  lookup_ethertype;
  logic                         lookup_valid;
  logic                         lookup_ack;
  logic                         overrun;
  logic [31:0]                  lut_hits;
  logic [31:0]                  lut_misses;

  modport master (
    output dst_mac, src_mac, ethertype, eth_done, src_port, lookup_ack,
    input  dst_ports, lookup_ethertype, lookup_valid, overrun, lut_hits, lut_misses
  );

  modport slave (
    input  dst_mac, src_mac, ethertype, eth_done, src_port, lookup_ack,
    output dst_ports, lookup_ethertype, lookup_valid, overrun, lut_hits, lut_misses
  );
endinterface

// File: rtl/mac_learning_table.sv
// mac_learning_table: register-based MAC learning table for the learning
// switch output_port_lookup path. Each parsed header looks up its dst_mac to
// produce a forwarding mask, then learns src_mac -> src_port. Results are
// held on a valid/ack handshake; one extra header can wait in a pending slot.
// Optional build macro MAC_LUT_AGING_EN adds per-entry age bits and a
// periodic aging sweep every AGE_PERIOD cycles.
module mac_learning_table #(
  parameter int NUM_IQ_BITS       = 3,
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter int LUT_DEPTH         = 16,
  parameter int LUT_DEPTH_BITS    = 4,
  parameter int AGE_PERIOD        = 100000000
) (
  input  logic                clk,
  input  logic                reset_n,
  mac_learning_table_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_LEARN  = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]                   state_q, state_d;
  logic                         ethDonePrev_q;

  logic [47:0]                  workDst_q, workSrc_q;
  logic [15:0]                  workType_q;
  logic [NUM_IQ_BITS-1:0]       workPort_q;

  logic                         pendValid_q, pendValid_d;
  logic [47:0]                  pendDst_q, pendSrc_q;
  logic [15:0]                  pendType_q;
  logic [NUM_IQ_BITS-1:0]       pendPort_q;

  logic [47:0]                  entryMac_q  [LUT_DEPTH];
  logic [NUM_IQ_BITS-1:0]       entryPort_q [LUT_DEPTH];
  logic [LUT_DEPTH-1:0]         entryValid_q;
  logic [LUT_DEPTH_BITS-1:0]    replacePtr_q;

  logic [NUM_OUTPUT_QUEUES-1:0] resMask_q;
  logic [NUM_OUTPUT_QUEUES-1:0] dstPorts_q;
  logic [15:0]                  lookupType_q;
  logic                         lookupValid_q;
  logic                         overrun_q;
  logic [31:0]                  hits_q, misses_q;

  logic                         trigger;
  logic                         respDone;
  logic                         loadWorkFromIn;
  logic                         loadWorkFromPend;
  logic                         capturePend;
  logic                         setOverrun;

  logic                         dstHit;
  logic [LUT_DEPTH_BITS-1:0]    dstHitIdx;
  logic                         srcHit;
  logic [LUT_DEPTH_BITS-1:0]    srcHitIdx;
  logic                         freeFound;
  logic [LUT_DEPTH_BITS-1:0]    freeIdx;
  logic [NUM_IQ_BITS-1:0]       hitPort;

  logic [NUM_OUTPUT_QUEUES-1:0] floodMask;
  logic [NUM_OUTPUT_QUEUES-1:0] lookupMask;
  logic                         isFlood;

  logic                         learnEn;
  logic                         usePtr;
  logic [LUT_DEPTH_BITS-1:0]    learnIdx;

`ifdef MAC_LUT_AGING_EN
  logic [LUT_DEPTH-1:0]         entryAge_q;
  logic [LUT_DEPTH-1:0]         touch;
  logic [31:0]                  ageCnt_q;
  logic                         ageSweep;
`else
  logic                         unusedAgePeriod;
  assign unusedAgePeriod = ^AGE_PERIOD;
`endif

  // Handshake decode: a header arrives on the rising edge of eth_done, and the
  // held result retires only on an ack while it is actually being presented.
  always_comb begin
    trigger          = bus.eth_done && !ethDonePrev_q;
    respDone         = (state_q == ST_RESP) && lookupValid_q && bus.lookup_ack;
    loadWorkFromPend = respDone && pendValid_q;
    loadWorkFromIn   = trigger && ((state_q == ST_IDLE) || (respDone && !pendValid_q));
    capturePend      = trigger && !loadWorkFromIn && (!pendValid_q || loadWorkFromPend);
    setOverrun       = trigger && !loadWorkFromIn && pendValid_q && !loadWorkFromPend;
    pendValid_d      = pendValid_q;
    if (capturePend) begin
      pendValid_d = 1'b1;
    end else if (loadWorkFromPend) begin
      pendValid_d = 1'b0;
    end
  end

  // Next-state logic: one cycle each for lookup and learn, then hold in RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (trigger) state_d = ST_LOOKUP;
      ST_LOOKUP: state_d = ST_LEARN;
      ST_LEARN:  state_d = ST_RESP;
      ST_RESP: begin
        if (respDone) begin
          state_d = (loadWorkFromPend || loadWorkFromIn) ? ST_LOOKUP : ST_IDLE;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Parallel search of all valid entries: dst lookup, src refresh match and
  // the lowest free slot for a new source.
  always_comb begin
    dstHit    = 1'b0;
    dstHitIdx = '0;
    srcHit    = 1'b0;
    srcHitIdx = '0;
    freeFound = 1'b0;
    freeIdx   = '0;
    for (int i = 0; i < LUT_DEPTH; i++) begin
      if (!dstHit && entryValid_q[i] && (entryMac_q[i] == workDst_q)) begin
        dstHit    = 1'b1;
        dstHitIdx = LUT_DEPTH_BITS'(i);
      end
      if (!srcHit && entryValid_q[i] && (entryMac_q[i] == workSrc_q)) begin
        srcHit    = 1'b1;
        srcHitIdx = LUT_DEPTH_BITS'(i);
      end
      if (!freeFound && !entryValid_q[i]) begin
        freeFound = 1'b1;
        freeIdx   = LUT_DEPTH_BITS'(i);
      end
    end
    hitPort = entryPort_q[dstHitIdx];
  end

  // Forwarding mask: flood to the even (MAC) ports minus the ingress port on
  // multicast or miss, one-hot on a hit, nothing when the hit points back at
  // the ingress port.
  always_comb begin
    floodMask = '0;
    for (int i = 0; i < NUM_OUTPUT_QUEUES; i += 2) begin
      floodMask[i] = 1'b1;
    end
    if (int'(workPort_q) < NUM_OUTPUT_QUEUES) begin
      floodMask[workPort_q] = 1'b0;
    end
    isFlood = workDst_q[40] || !dstHit;
    if (isFlood) begin
      lookupMask = floodMask;
    end else if (hitPort == workPort_q) begin
      lookupMask = '0;
    end else begin
      lookupMask = NUM_OUTPUT_QUEUES'(1) << hitPort;
    end
  end

  // Learn target: refresh a known source, else fill the lowest free slot,
  // else evict round-robin. Multicast sources are never learned.
  always_comb begin
    learnEn = (state_q == ST_LEARN) && !workSrc_q[40];
    usePtr  = 1'b0;
    if (srcHit) begin
      learnIdx = srcHitIdx;
    end else if (freeFound) begin
      learnIdx = freeIdx;
    end else begin
      learnIdx = replacePtr_q;
      usePtr   = learnEn;
    end
  end

`ifdef MAC_LUT_AGING_EN
  // Entries touched this cycle by a learn or a dst hit; they survive a sweep.
  always_comb begin
    touch = '0;
    if (learnEn) begin
      touch[learnIdx] = 1'b1;
    end
    if ((state_q == ST_LOOKUP) && dstHit) begin
      touch[dstHitIdx] = 1'b1;
    end
    ageSweep = (ageCnt_q == 32'(AGE_PERIOD - 1));
  end

  // Free-running aging timer that wraps once per sweep period.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ageCnt_q <= '0;
    end else if (ageSweep) begin
      ageCnt_q <= '0;
    end else begin
      ageCnt_q <= ageCnt_q + 32'd1;
    end
  end

  // Age bits: set on use, all cleared by a sweep except entries used right now.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      entryAge_q <= '0;
    end else if (ageSweep) begin
      entryAge_q <= touch;
    end else begin
      entryAge_q <= entryAge_q | touch;
    end
  end
`endif

  // Entry valid bits and the round-robin replace pointer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      entryValid_q <= '0;
      replacePtr_q <= '0;
    end else begin
`ifdef MAC_LUT_AGING_EN
      for (int i = 0; i < LUT_DEPTH; i++) begin
        if (ageSweep && !entryAge_q[i] && !touch[i]) begin
          entryValid_q[i] <= 1'b0;
        end
      end
`endif
      if (learnEn) begin
        entryValid_q[learnIdx] <= 1'b1;
      end
      if (usePtr) begin
        replacePtr_q <= (replacePtr_q == LUT_DEPTH_BITS'(LUT_DEPTH - 1)) ?
                        '0 : replacePtr_q + LUT_DEPTH_BITS'(1);
      end
    end
  end

  // Entry payload storage; only meaningful where the valid bit is set.
  always_ff @(posedge clk) begin
    if (learnEn) begin
      entryMac_q[learnIdx]  <= workSrc_q;
      entryPort_q[learnIdx] <= workPort_q;
    end
  end

  // Working and pending header registers, loaded from the parser or from the
  // pending slot when the previous result retires.
  always_ff @(posedge clk) begin
    if (loadWorkFromIn) begin
      workDst_q  <= bus.dst_mac;
      workSrc_q  <= bus.src_mac;
      workType_q <= bus.ethertype;
      workPort_q <= bus.src_port;
    end else if (loadWorkFromPend) begin
      workDst_q  <= pendDst_q;
      workSrc_q  <= pendSrc_q;
      workType_q <= pendType_q;
      workPort_q <= pendPort_q;
    end
    if (capturePend) begin
      pendDst_q  <= bus.dst_mac;
      pendSrc_q  <= bus.src_mac;
      pendType_q <= bus.ethertype;
      pendPort_q <= bus.src_port;
    end
  end

  // Control state, result registers, handshake outputs and statistics.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      ethDonePrev_q <= 1'b0;
      pendValid_q   <= 1'b0;
      overrun_q     <= 1'b0;
      resMask_q     <= '0;
      dstPorts_q    <= '0;
      lookupType_q  <= '0;
      lookupValid_q <= 1'b0;
      hits_q        <= '0;
      misses_q      <= '0;
    end else begin
      state_q       <= state_d;
      ethDonePrev_q <= bus.eth_done;
      pendValid_q   <= pendValid_d;
      if (setOverrun) begin
        overrun_q <= 1'b1;
      end
      if (state_q == ST_LOOKUP) begin
        resMask_q <= lookupMask;
        if (isFlood) begin
          misses_q <= misses_q + 32'd1;
        end else begin
          hits_q <= hits_q + 32'd1;
        end
      end
      if ((state_q == ST_RESP) && !lookupValid_q) begin
        lookupValid_q <= 1'b1;
        dstPorts_q    <= resMask_q;
        lookupType_q  <= workType_q;
      end else if (respDone) begin
        lookupValid_q <= 1'b0;
      end
    end
  end

  assign bus.dst_ports        = dstPorts_q;
  assign bus.lookup_ethertype = lookupType_q;
  assign bus.lookup_valid     = lookupValid_q;
  assign bus.overrun          = overrun_q;
  assign bus.lut_hits         = hits_q;
  assign bus.lut_misses       = misses_q;

endmodule

// File: tb/tb_mac_learning_table.sv
// Self-checking bench for mac_learning_table. Stimulus pushes the expected
// forwarding result into a scoreboard queue; an independent monitor pops and
// compares at every accepted result. Aging expectations follow the
// MAC_LUT_AGING_EN build macro, with AGE_PERIOD shortened to 100 cycles.
module tb_mac_learning_table;

  typedef struct {
    logic [7:0]  mask;
    logic [15:0] etype;
    bit          checkLat;
    int          expCyc;
  } expItem_t;

  logic     clk = 1'b0;
  logic     reset_n = 1'b0;
  int       cyc = 0;
  int       checks = 0;
  int       errors = 0;
  expItem_t sbQ[$];
  expItem_t monItem;
  bit       prevValid = 1'b0;
  int       riseCyc = 0;

  mac_learning_table_if #(.NUM_IQ_BITS(3), .NUM_OUTPUT_QUEUES(8)) bus ();

  mac_learning_table #(
    .NUM_IQ_BITS(3),
    .NUM_OUTPUT_QUEUES(8),
    .LUT_DEPTH(16),
    .LUT_DEPTH_BITS(4),
    .AGE_PERIOD(100)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // 100 MHz clock and a cycle counter used for latency checks.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Give up loudly rather than hang if something never completes.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] floodExp(input logic [2:0] port);
    floodExp = 8'h55 & ~(8'h01 << port);
  endfunction

  function automatic logic [47:0] seqMac(input int k);
    seqMac = 48'h0000_0000_1000 + 48'(k);
  endfunction

  // Scoreboard monitor: compare every accepted result against the queue.
  always @(negedge clk) begin
    if (!reset_n) begin
      prevValid = 1'b0;
    end else begin
      if (bus.lookup_valid && !prevValid) riseCyc = cyc;
      prevValid = bus.lookup_valid;
      if (bus.lookup_valid && bus.lookup_ack) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_result", 64'(bus.lookup_valid), 64'd0);
        end else begin
          monItem = sbQ.pop_front();
          checkOutput("dst_ports", 64'(bus.dst_ports), 64'(monItem.mask));
          checkOutput("lookup_ethertype", 64'(bus.lookup_ethertype), 64'(monItem.etype));
          if (monItem.checkLat) begin
            checkOutput("valid_latency", 64'(riseCyc), 64'(monItem.expCyc));
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic [47:0] dst, input logic [47:0] src,
                               input logic [15:0] et, input logic [2:0] port,
                               input logic [7:0] expMask, input bit checkLat,
                               input bit expectResult);
    expItem_t it;
    @(negedge clk);
    bus.dst_mac   = dst;
    bus.src_mac   = src;
    bus.ethertype = et;
    bus.src_port  = port;
    bus.eth_done  = 1'b1;
    if (expectResult) begin
      it.mask     = expMask;
      it.etype    = et;
      it.checkLat = checkLat;
      it.expCyc   = cyc + 4;
      sbQ.push_back(it);
    end
    @(negedge clk);
    bus.eth_done = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sbQ.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_timeout", 64'(sbQ.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset_n        = 1'b0;
    bus.eth_done   = 1'b0;
    bus.lookup_ack = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    checkOutput("reset_dst_ports", 64'(bus.dst_ports), 64'd0);
    checkOutput("reset_ethertype", 64'(bus.lookup_ethertype), 64'd0);
    checkOutput("reset_valid", 64'(bus.lookup_valid), 64'd0);
    checkOutput("reset_overrun", 64'(bus.overrun), 64'd0);
    checkOutput("reset_hits", 64'(bus.lut_hits), 64'd0);
    checkOutput("reset_misses", 64'(bus.lut_misses), 64'd0);
  endtask

  // Directed test sequence.
  initial begin
    bus.dst_mac    = '0;
    bus.src_mac    = '0;
    bus.ethertype  = '0;
    bus.src_port   = '0;
    bus.eth_done   = 1'b0;
    bus.lookup_ack = 1'b1;
    applyReset();

    // Basic flood, hit, filter and multicast behaviour.
    applyStimulus(48'h0000_0000_000B, 48'h0000_0000_000A, 16'h0800, 3'd2, 8'b0101_0001, 1'b1, 1'b1);
    waitDrain();
    checkOutput("misses_after_first", 64'(bus.lut_misses), 64'd1);
    checkOutput("hits_after_first", 64'(bus.lut_hits), 64'd0);
    applyStimulus(48'h0000_0000_000A, 48'h0000_0000_000B, 16'h86DD, 3'd4, 8'b0000_0100, 1'b1, 1'b1);
    waitDrain();
    checkOutput("hits_after_hit", 64'(bus.lut_hits), 64'd1);
    applyStimulus(48'h0000_0000_000A, 48'h0000_0000_000A, 16'h0806, 3'd2, 8'b0000_0000, 1'b1, 1'b1);
    waitDrain();
    checkOutput("hits_after_filter", 64'(bus.lut_hits), 64'd2);
    applyStimulus(48'h0100_5E00_0001, 48'h0100_0000_0099, 16'h0800, 3'd1, 8'b0101_0101, 1'b1, 1'b1);
    waitDrain();
    checkOutput("misses_after_mcast", 64'(bus.lut_misses), 64'd2);

    // Fill the table with 17 sources; the 17th evicts entry 0.
    applyReset();
    for (int k = 0; k < 17; k++) begin
      applyStimulus(48'h0000_0000_2000, seqMac(k), 16'h0800, 3'(k % 8), floodExp(3'(k % 8)), 1'b1, 1'b1);
      waitDrain();
    end
    applyStimulus(seqMac(0), seqMac(1), 16'h0800, 3'd1, 8'h55, 1'b1, 1'b1);
    waitDrain();
    applyStimulus(seqMac(16), seqMac(1), 16'h0800, 3'd1, 8'h01, 1'b1, 1'b1);
    waitDrain();
    applyStimulus(seqMac(2), seqMac(1), 16'h0800, 3'd1, 8'h04, 1'b1, 1'b1);
    waitDrain();
    applyStimulus(seqMac(16), seqMac(17), 16'h0800, 3'd5, 8'h01, 1'b1, 1'b1);
    waitDrain();
    applyStimulus(seqMac(1), seqMac(2), 16'h0800, 3'd2, 8'h51, 1'b1, 1'b1);
    waitDrain();
    checkOutput("hits_after_fill", 64'(bus.lut_hits), 64'd3);
    checkOutput("misses_after_fill", 64'(bus.lut_misses), 64'd19);

    // Back-pressure: one header waits in pending, the next one is lost.
    @(posedge clk);
    #1 bus.lookup_ack = 1'b0;
    applyStimulus(seqMac(16), seqMac(2), 16'h1111, 3'd2, 8'h01, 1'b1, 1'b1);
    applyStimulus(seqMac(2), seqMac(3), 16'h2222, 3'd3, 8'h04, 1'b0, 1'b1);
    checkOutput("overrun_before", 64'(bus.overrun), 64'd0);
    applyStimulus(seqMac(2), seqMac(4), 16'h3333, 3'd4, 8'h00, 1'b0, 1'b0);
    checkOutput("overrun_set", 64'(bus.overrun), 64'd1);
    repeat (5) @(negedge clk);
    checkOutput("valid_held", 64'(bus.lookup_valid), 64'd1);
    checkOutput("dst_ports_held", 64'(bus.dst_ports), 64'h01);
    @(posedge clk);
    #1 bus.lookup_ack = 1'b1;
    waitDrain();
    checkOutput("overrun_sticky", 64'(bus.overrun), 64'd1);
    checkOutput("hits_after_pending", 64'(bus.lut_hits), 64'd5);
    checkOutput("misses_after_pending", 64'(bus.lut_misses), 64'd19);

    // Aging: a learned entry left idle across two sweeps.
    applyReset();
    applyStimulus(48'h0000_0000_000B, 48'h0000_0000_000A, 16'h0800, 3'd2, 8'h51, 1'b1, 1'b1);
    waitDrain();
    repeat (250) @(negedge clk);
`ifdef MAC_LUT_AGING_EN
    applyStimulus(48'h0000_0000_000A, 48'h0000_0000_000B, 16'h0800, 3'd4, 8'h45, 1'b1, 1'b1);
    waitDrain();
    checkOutput("aged_hits", 64'(bus.lut_hits), 64'd0);
    checkOutput("aged_misses", 64'(bus.lut_misses), 64'd2);
`else
    applyStimulus(48'h0000_0000_000A, 48'h0000_0000_000B, 16'h0800, 3'd4, 8'h04, 1'b1, 1'b1);
    waitDrain();
    checkOutput("persist_hits", 64'(bus.lut_hits), 64'd1);
    checkOutput("persist_misses", 64'(bus.lut_misses), 64'd1);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_learning_table.md
Name: mac_learning_table

Overview:
- Downstream consumer of the Ethernet header parser in the learning switch output_port_lookup path.
- On each parsed header it looks up dst_mac in a small register-based MAC table and returns a destination port mask.
- It then learns src_mac → src_port.
- Results are handed to the packet-forwarding stage through a valid/ack handshake.

Parameters:
NUM_IQ_BITS, 3, width of src_port / stored port number
NUM_OUTPUT_QUEUES, 8, width of dst_ports mask
LUT_DEPTH, 16, number of table entries
LUT_DEPTH_BITS, 4, log2(LUT_DEPTH)
AGE_PERIOD, 100000000, cycles per aging sweep (used only with the aging macro)

Ports:
clk  in  1  clock; all logic is on its rising edge
reset_n  in  1  synchronous, active-low reset
dst_mac  in  48  destination MAC from the parser
src_mac  in  48  source MAC from the parser
ethertype  in  16  unused except for pass-through to lookup_ethertype
eth_done  in  1  high from header parsed until EOP
src_port  in  NUM_IQ_BITS  input queue of the current packet
dst_ports  out  NUM_OUTPUT_QUEUES  forwarding mask
lookup_ethertype  out  16  ethertype of the packet the result belongs to
lookup_valid  out  1  result valid; held until acknowledged
lookup_ack  in  1  consumer accepts the result
overrun  out  1  sticky: a header was lost
lut_hits  out  32  dst lookup hit counter, wraps
lut_misses  out  32  dst lookup miss/flood counter, wraps

Behaviour:
- Reset (reset_n=0 at a clk edge): all entries invalid, replace pointer 0, state IDLE, pending clear.
  Outputs: dst_ports=0, lookup_ethertype=0, lookup_valid=0, overrun=0, counters=0.
- Reset mid-operation aborts the in-flight lookup with no table write.
- Trigger: eth_done=1 at an edge when it was 0 at the previous edge. On trigger, dst_mac, src_mac, ethertype and src_port are captured.
- State IDLE: trigger → LOOKUP.
- State LOOKUP (1 cycle): parallel compare of the captured dst_mac against all valid entries; result registered → LEARN.
- State LEARN (1 cycle): update the table → RESP. lookup_valid rises at the first edge after LEARN, i.e. 3 cycles after the trigger edge.
  - If src_mac matches a valid entry, overwrite that entry's port.
  - Else write to the lowest-index invalid entry.
  - Else write to the entry at the replace pointer; pointer increments mod LUT_DEPTH (wraps 15→0).
  - If src_mac[40]=1 (multicast source), do not learn.
- State RESP: lookup_valid=1 with dst_ports and lookup_ethertype stable until an edge with lookup_ack=1.
  - On that edge lookup_valid clears.
  - Then → LOOKUP if pending is set (pending fields move to the working registers), else → IDLE.
  - lookup_ack while lookup_valid=0 is ignored.
- Mask rules:
  - dst_mac[40]=1, or lookup miss: flood. Set all even bits below NUM_OUTPUT_QUEUES (MAC ports), then clear bit src_port.
  - Hit: one-hot bit at the stored port.
  - Hit whose stored port equals src_port: dst_ports=0 (filter).
- Counters: lut_hits increments on a unicast hit; lut_misses increments on a miss or flood.
- Lookup precedes learning: a packet never hits on its own source-learn.
- Pending: a trigger outside IDLE captures into a one-deep pending register. A trigger while pending is already set sets overrun, and the new header is discarded. overrun clears only on reset.

Optional Feature:
- Macro MAC_LUT_AGING_EN.
- Defined:
  - Each entry has an age bit, set on learn, refresh, or hit.
  - A free-running counter expires every AGE_PERIOD cycles. At expiry, entries with age=0 are invalidated and all age bits cleared.
  - Learn or hit in the same cycle as a sweep: the entry stays valid with age=1.
- Undefined: no timer, no age bits; entries persist until replaced. AGE_PERIOD is ignored.

Test Plan:
- Empty table, packet src_port=2, dst 00:00:00:00:00:0B, src ...:0A → dst_ports=8'b0101_0001 (flood minus bit 2), lookup_valid at trigger+3, lut_misses=1, entry ...:0A→2 learned.
- Then packet from port 4, dst ...:0A → dst_ports=8'b0000_0100, lut_hits=1.
- Packet from port 2, dst ...:0A → dst_ports=0 (filter).
- Learn 17 distinct sources → 17th overwrites entry 0, pointer=1; lookup of the first MAC floods.
- Hold lookup_ack=0; give two more triggers → first is pending and served after ack; second sets overrun=1.
- With MAC_LUT_AGING_EN and AGE_PERIOD=100, learn ...:0A and leave it idle → after two sweeps the lookup floods; with the macro off it still hits.
